// File: rtl/freq_measure_sequencer_if.sv
// -----------------------------------------------------------------------------
// freq_measure_sequencer_if
//   Avalon-MM byte bus between the measurement sequencer (master) and the
//   8-bit frequency-measurement slave.
//
//   address    4  slave register address
//   write      1  write strobe, one cycle per access
//   read       1  read strobe, held for the whole read access
//   writedata  8  write data
//   readdata   8  read data, valid READ_LATENCY cycles after the read starts
// -----------------------------------------------------------------------------
interface freq_measure_sequencer_if;
    logic [3:0] address;
    logic       write;
    logic       read;
    logic [7:0] writedata;
    logic [7:0] readdata;

    modport master (
        output address,
        output write,
        output read,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  write,
        input  read,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/freq_measure_sequencer.sv
// -----------------------------------------------------------------------------
// freq_measure_sequencer
//   Avalon-MM master that drives the 8-bit frequency-measurement slave. It
//   pulses the counter reset, polls the ready bit, then reads the
//   signal-count and reference-count bytes. The control side only sees a
//   start/result interface.
//
//   Slave map: 0 counter reset (bit0), 1 ready (bit0),
//              2..5 signal count LSB first, 6..9 reference count LSB first.
//
//   Ports:
//     csi_MCLK_clk      in   system clock, rising edge
//     rsi_MRST_reset_n  in   synchronous active-low reset
//     start             in   one-cycle request to begin a measurement
//     abort             in   one-cycle request to cancel the measurement
//     auto_repeat       in   (FMS_AUTO_REPEAT_EN only) restart after DONE
//     busy              out  sequence in progress
//     result_valid      out  counts valid
//     error_timeout     out  ready bit never seen within TIMEOUT_CYCLES
//     count_sig         out  32-bit gated signal count
//     count_ref         out  32-bit reference-clock count
//     avm_meas          master modport of freq_measure_sequencer_if
//
//   Optional feature, macro FMS_AUTO_REPEAT_EN: adds auto_repeat; when set
//   on leaving DONE the sequence restarts at CLR_SET and result_valid is a
//   one-cycle pulse per result.
// -----------------------------------------------------------------------------
module freq_measure_sequencer #(
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned RST_CYCLES     = 4,
    parameter int unsigned POLL_GAP       = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
    input  logic        csi_MCLK_clk,
    input  logic        rsi_MRST_reset_n,
    input  logic        start,
    input  logic        abort,
`ifdef FMS_AUTO_REPEAT_EN
    input  logic        auto_repeat,
`endif
    output logic        busy,
    output logic        result_valid,
    output logic        error_timeout,
    output logic [31:0] count_sig,
    output logic [31:0] count_ref,
    freq_measure_sequencer_if.master avm_meas
);

    typedef enum logic [3:0] {
        IDLE,
        CLR_SET,
        CLR_REL,
        POLL,
        GAP,
        FETCH,
        DONE,
        ERROR,
        ABORT_WR
    } state_t;

    localparam logic [31:0] RD_LAST  = 32'(READ_LATENCY);
    localparam logic [31:0] RST_LAST = 32'(RST_CYCLES - 1);
    localparam logic [31:0] GAP_LAST = 32'(POLL_GAP - 1);
    localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_CYCLES);

    localparam logic [3:0] ADDR_CTRL  = 4'd0;
    localparam logic [3:0] ADDR_READY = 4'd1;
    localparam logic [3:0] ADDR_DATA0 = 4'd2;

    state_t      state;
    logic [31:0] phase_cnt;   // cycles spent in the current access / wait
    logic [31:0] to_cnt;      // saturating POLL/GAP cycle counter
    logic [2:0]  fetch_idx;   // byte index 0..7 during FETCH
    logic [63:0] shadow;      // bytes 2..9 collected before DONE commits them
    logic        abort_pend;  // abort seen while an access was in flight

    logic abort_now;
    logic rd_last;
    logic to_hit;

    assign abort_now = abort | abort_pend;
    // Readdata is sampled on the edge that closes a READ_LATENCY+1 cycle read.
    assign rd_last   = (phase_cnt == RD_LAST);
    assign to_hit    = (TO_LIMIT != 32'd0) && (to_cnt >= TO_LIMIT);

    always_ff @(posedge csi_MCLK_clk) begin
        if (!rsi_MRST_reset_n) begin
            state              <= IDLE;
            phase_cnt          <= '0;
            to_cnt             <= '0;
            fetch_idx          <= '0;
            shadow             <= '0;
            abort_pend         <= 1'b0;
            busy               <= 1'b0;
            result_valid       <= 1'b0;
            error_timeout      <= 1'b0;
            count_sig          <= '0;
            count_ref          <= '0;
            avm_meas.address   <= '0;
            avm_meas.write     <= 1'b0;
            avm_meas.read      <= 1'b0;
            avm_meas.writedata <= '0;
        end else begin
            // NOTE: non-blocking only; a later assignment in this block to the
            // same register overrides these defaults, so write is a
            // one-cycle strobe unless a state re-arms it.
            avm_meas.write <= 1'b0;

            if (state != IDLE && abort) begin
                abort_pend <= 1'b1;
            end

            if ((state == POLL || state == GAP) && (to_cnt != '1)) begin
                to_cnt <= to_cnt + 32'd1;
            end

            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        result_valid       <= 1'b0;
                        error_timeout      <= 1'b0;
                        busy               <= 1'b1;
                        abort_pend         <= 1'b0;
                        phase_cnt          <= '0;
                        avm_meas.write     <= 1'b1;
                        avm_meas.address   <= ADDR_CTRL;
                        avm_meas.writedata <= 8'h01;
                        state              <= CLR_SET;
                    end
                end

                // First cycle carries the write; the rest hold the bus idle
                // so the counter reset stays asserted RST_CYCLES in total.
                CLR_SET: begin
`ifdef FMS_AUTO_REPEAT_EN
                    // Ends the one-cycle result pulse on an automatic restart.
                    result_valid <= 1'b0;
`endif
                    if (abort_now) begin
                        avm_meas.write     <= 1'b1;
                        avm_meas.address   <= ADDR_CTRL;
                        avm_meas.writedata <= 8'h00;
                        abort_pend         <= 1'b0;
                        state              <= ABORT_WR;
                    end else if (phase_cnt == RST_LAST) begin
                        avm_meas.write     <= 1'b1;
                        avm_meas.address   <= ADDR_CTRL;
                        avm_meas.writedata <= 8'h00;
                        state              <= CLR_REL;
                    end else begin
                        phase_cnt <= phase_cnt + 32'd1;
                    end
                end

                CLR_REL: begin
                    if (abort_now) begin
                        avm_meas.write     <= 1'b1;
                        avm_meas.address   <= ADDR_CTRL;
                        avm_meas.writedata <= 8'h00;
                        abort_pend         <= 1'b0;
                        state              <= ABORT_WR;
                    end else begin
                        avm_meas.read    <= 1'b1;
                        avm_meas.address <= ADDR_READY;
                        phase_cnt        <= '0;
                        to_cnt           <= '0;
                        state            <= POLL;
                    end
                end

                POLL: begin
                    if (rd_last) begin
                        avm_meas.read <= 1'b0;
                        if (abort_now) begin
                            avm_meas.write     <= 1'b1;
                            avm_meas.address   <= ADDR_CTRL;
                            avm_meas.writedata <= 8'h00;
                            abort_pend         <= 1'b0;
                            state              <= ABORT_WR;
                        end else if (to_hit) begin
                            avm_meas.write     <= 1'b1;
                            avm_meas.address   <= ADDR_CTRL;
                            avm_meas.writedata <= 8'h01;
                            state              <= ERROR;
                        end else if (avm_meas.readdata[0]) begin
                            avm_meas.read    <= 1'b1;
                            avm_meas.address <= ADDR_DATA0;
                            phase_cnt        <= '0;
                            fetch_idx        <= '0;
                            state            <= FETCH;
                        end else begin
                            phase_cnt <= '0;
                            state     <= GAP;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 32'd1;
                    end
                end

                // No access is in flight here, so abort and timeout act at once.
                GAP: begin
                    if (abort_now) begin
                        avm_meas.write     <= 1'b1;
                        avm_meas.address   <= ADDR_CTRL;
                        avm_meas.writedata <= 8'h00;
                        abort_pend         <= 1'b0;
                        state              <= ABORT_WR;
                    end else if (to_hit) begin
                        avm_meas.write     <= 1'b1;
                        avm_meas.address   <= ADDR_CTRL;
                        avm_meas.writedata <= 8'h01;
                        state              <= ERROR;
                    end else if (phase_cnt == GAP_LAST) begin
                        avm_meas.read    <= 1'b1;
                        avm_meas.address <= ADDR_READY;
                        phase_cnt        <= '0;
                        state            <= POLL;
                    end else begin
                        phase_cnt <= phase_cnt + 32'd1;
                    end
                end

                // Back-to-back reads of 2..9; read stays high across accesses.
                FETCH: begin
                    if (rd_last) begin
                        shadow[{fetch_idx, 3'b000} +: 8] <= avm_meas.readdata;
                        phase_cnt <= '0;
                        if (abort_now) begin
                            avm_meas.read      <= 1'b0;
                            avm_meas.write     <= 1'b1;
                            avm_meas.address   <= ADDR_CTRL;
                            avm_meas.writedata <= 8'h00;
                            abort_pend         <= 1'b0;
                            state              <= ABORT_WR;
                        end else if (fetch_idx == 3'd7) begin
                            avm_meas.read <= 1'b0;
                            state         <= DONE;
                        end else begin
                            fetch_idx        <= fetch_idx + 3'd1;
                            avm_meas.address <= avm_meas.address + 4'd1;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 32'd1;
                    end
                end

                // Counts are committed as a whole here and nowhere else.
                DONE: begin
                    if (abort_now) begin
                        avm_meas.write     <= 1'b1;
                        avm_meas.address   <= ADDR_CTRL;
                        avm_meas.writedata <= 8'h00;
                        abort_pend         <= 1'b0;
                        state              <= ABORT_WR;
                    end else begin
                        count_sig    <= shadow[31:0];
                        count_ref    <= shadow[63:32];
                        result_valid <= 1'b1;
`ifdef FMS_AUTO_REPEAT_EN
                        if (auto_repeat) begin
                            phase_cnt          <= '0;
                            avm_meas.write     <= 1'b1;
                            avm_meas.address   <= ADDR_CTRL;
                            avm_meas.writedata <= 8'h01;
                            state              <= CLR_SET;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
`else
                        busy  <= 1'b0;
                        state <= IDLE;
`endif
                    end
                end

                // Write cycle that parks the counter in reset.
                ERROR: begin
                    error_timeout <= 1'b1;
                    busy          <= 1'b0;
                    abort_pend    <= 1'b0;
                    state         <= IDLE;
                end

                // Write cycle that releases the counter after an abort.
                ABORT_WR: begin
                    busy       <= 1'b0;
                    abort_pend <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/freq_measure_sequencer.md
Name: freq_measure_sequencer

Overview:
- Avalon-MM master that runs the 8-bit frequency-measurement slave: clear, wait for gate completion, read both 32-bit counts.
- Slave map: addr 0 = counter reset (bit0, R/W); addr 1 = ready (bit0); addr 2..5 = signal count bytes LSB first; addr 6..9 = reference-clock count bytes LSB first.
- Sits between the slave and the system's control logic, which sees a start/result interface and no byte-level bus traffic.

Parameters:
- READ_LATENCY, 1, cycles from address/read presented to readdata valid (1..3)
- RST_CYCLES, 4, cycles counter reset is held at 1 (min 2)
- POLL_GAP, 8, idle cycles between consecutive ready polls
- TIMEOUT_CYCLES, 100000000, max cycles in POLL before error; 0 disables timeout

Ports:
- csi_MCLK_clk  in  1  system clock; all logic on rising edge
- rsi_MRST_reset_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle request to begin a measurement
- abort  in  1  one-cycle request to cancel the current measurement
- busy  out  1  sequence in progress
- result_valid  out  1  counts valid; held until next accepted start
- error_timeout  out  1  ready never seen; held until next accepted start
- count_sig  out  32  frequency-gated count (bytes 2..5)
- count_ref  out  32  reference-clock count (bytes 6..9)
- avm_meas_address  out  4  slave address
- avm_meas_write  out  1  write strobe
- avm_meas_read  out  1  read strobe
- avm_meas_writedata  out  8  write data
- avm_meas_readdata  in  8  read data

Behaviour:
- Reset (rsi_MRST_reset_n=0 at a clock edge): state IDLE; all outputs 0, including bus strobes, address, writedata, counts and flags. Reset mid-sequence drops to IDLE with strobes low the next cycle; no bus cycle is completed.
- Write access: exactly 1 cycle with write=1, address and writedata stable.
- Read access: READ_LATENCY+1 cycles with read=1 and address held. readdata is captured at the final edge.
- write and read are never high together.

States:
- IDLE: busy=0. On start (and no abort), clear result_valid and error_timeout, then go to CLR_SET.
- CLR_SET: write addr0=0x01. Then hold bus idle for RST_CYCLES-1 further cycles (RST_CYCLES total), then go to CLR_REL.
- CLR_REL: write addr0=0x00, then go to POLL.
- POLL: read addr1. If readdata[0]=1, go to FETCH; else go to GAP.
- GAP: strobes low for POLL_GAP cycles, then return to POLL.
- FETCH: 8 reads, addr 2..9 ascending, back-to-back. Byte k goes into a shadow register. Then go to DONE.
- DONE: copy shadows to count_sig/count_ref, set result_valid=1 (same edge), then go to IDLE.
- ERROR: issue one write addr0=0x01 to park the counter, set error_timeout=1, then go to IDLE.

Timers and counters:
- busy=1 in every state except IDLE.
- Timeout counter: 32 bits, cleared on entry to the first POLL, counts every cycle in POLL/GAP. When it reaches TIMEOUT_CYCLES (nonzero), go to ERROR at the end of the current access.
- The counter saturates; it never wraps.

Abort and boundaries:
- abort while busy: finish the current bus access, then write addr0=0x00 and go to IDLE. result_valid and error_timeout stay 0; counts keep their old values.
- abort in IDLE is ignored. abort and start in the same IDLE cycle: abort wins, nothing starts.
- start while busy is ignored and not queued.
- count_sig/count_ref update only in DONE, never partially.
- Counts 0xFFFFFFFF and 0x00000000 pass through unmodified.

Optional Feature:
- Macro: FMS_AUTO_REPEAT_EN.
- Defined: adds input auto_repeat (1 bit). If auto_repeat=1 when leaving DONE, the next state is CLR_SET instead of IDLE.
  - result_valid pulses for exactly 1 cycle per result; counts are held until the next DONE.
  - busy stays 1 across repeats.
  - abort ends repetition. ERROR always ends in IDLE.
- Undefined: no auto_repeat port; DONE always goes to IDLE; behaviour is exactly as above.

Test Plan:
- Ready on first poll:
  - Stimulus: after reset, start=1 for 1 cycle; slave model returns ready=1 on the first poll, bytes 2..9 = 0x78,0x56,0x34,0x12,0xEF,0xCD,0xAB,0x89.
  - Response: count_sig=0x12345678, count_ref=0x89ABCDEF, result_valid=1.
  - Bus trace (READ_LATENCY=1): 1 write addr0=1, 3 idle, write addr0=0, 2-cycle read addr1, 8 two-cycle reads.
- Ready on third poll:
  - Stimulus: ready=1 only on the third poll.
  - Response: exactly 2 GAP windows of 8 cycles; 3 addr1 reads; result_valid set after 8 further reads.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=50, ready never set.
  - Response: error_timeout=1, final bus write addr0=0x01, busy=0, result_valid=0, counts unchanged.
- Abort and start:
  - Stimulus: abort asserted in GAP during the second measurement.
  - Response: final write addr0=0x00, IDLE, result_valid=0, counts keep the first measurement's values.
  - Stimulus: start+abort together in IDLE. Response: no bus activity.
- Reset mid-operation:
  - Stimulus: rsi_MRST_reset_n=0 for 1 cycle during FETCH byte 5.
  - Response: next cycle all outputs 0 and strobes low; a later start runs a full clean sequence.
- FMS_AUTO_REPEAT_EN, auto_repeat=1:
  - Stimulus: two successive measurements with distinct data.
  - Response: two 1-cycle result_valid pulses, busy continuously 1, counts updated to the second data set.
